// File: rtl/mem_req_arbiter.sv
// Round-robin arbiter sharing one main-memory port between the icache and dcache.
// One transaction outstanding; sequences request, write-data and read-response channels.
module mem_req_arbiter #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 128,
    parameter int unsigned MASK_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  reset,

    input  logic                  ic_req_valid,
    output logic                  ic_req_ready,
    input  logic [ADDR_WIDTH-1:0] ic_req_addr,
    output logic                  ic_resp_valid,
    output logic [DATA_WIDTH-1:0] ic_resp_data,

    input  logic                  dc_req_valid,
    output logic                  dc_req_ready,
    input  logic                  dc_req_rw,
    input  logic [ADDR_WIDTH-1:0] dc_req_addr,
    input  logic [DATA_WIDTH-1:0] dc_req_wdata,
    input  logic [MASK_WIDTH-1:0] dc_req_wmask,
    output logic                  dc_resp_valid,
    output logic [DATA_WIDTH-1:0] dc_resp_data,

    output logic                  mem_req_valid,
    input  logic                  mem_req_ready,
    output logic                  mem_req_rw,
    output logic [ADDR_WIDTH-1:0] mem_req_addr,
    output logic                  mem_wdata_valid,
    input  logic                  mem_wdata_ready,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    output logic [MASK_WIDTH-1:0] mem_wmask,
    input  logic                  mem_resp_valid,
    input  logic [DATA_WIDTH-1:0] mem_resp_data,

    output logic                  busy,
    output logic                  owner
);

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        RESP
    } state_t;

    state_t state_q, state_d;

    logic last_grant_q;   // 0 = icache, 1 = dcache
    logic owner_q;
    logic rw_q;
    logic req_done_q;
    logic wdata_done_q;

    logic grant_dc;
    logic accept;
    logic req_fire;
    logic wdata_fire;
    logic write_done;
    logic resp_take;

    // dcache wins when it is the only requester, or on a tie when icache went last
    assign grant_dc = dc_req_valid && (!ic_req_valid || !last_grant_q);

    assign mem_req_valid   = (state_q == REQ) && !req_done_q;
    assign mem_wdata_valid = (state_q == REQ) && rw_q && !wdata_done_q;
    assign req_fire        = mem_req_valid && mem_req_ready;
    assign wdata_fire      = mem_wdata_valid && mem_wdata_ready;

    assign mem_req_rw = rw_q;
    assign busy       = (state_q != IDLE);
    assign owner      = owner_q;

    always_comb begin
        state_d      = state_q;
        ic_req_ready = 1'b0;
        dc_req_ready = 1'b0;
        accept       = 1'b0;
        write_done   = 1'b0;
        resp_take    = 1'b0;
        case (state_q)
            IDLE: begin
                if (ic_req_valid || dc_req_valid) begin
                    accept       = 1'b1;
                    dc_req_ready = grant_dc;
                    ic_req_ready = !grant_dc;
                    state_d      = REQ;
                end
            end
            REQ: begin
                if (!rw_q) begin
                    if (req_fire) begin
                        state_d = RESP;
                    end
                end else if ((req_done_q || req_fire) && (wdata_done_q || wdata_fire)) begin
                    // both channels may fire in the same cycle or in either order
                    write_done = 1'b1;
                    state_d    = IDLE;
                end
            end
            RESP: begin
                if (mem_resp_valid) begin
                    resp_take = 1'b1;
                    state_d   = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= IDLE;
            last_grant_q  <= 1'b0;
            owner_q       <= 1'b0;
            rw_q          <= 1'b0;
            req_done_q    <= 1'b0;
            wdata_done_q  <= 1'b0;
            mem_req_addr  <= '0;
            mem_wdata     <= '0;
            mem_wmask     <= '0;
            ic_resp_valid <= 1'b0;
            dc_resp_valid <= 1'b0;
            ic_resp_data  <= '0;
            dc_resp_data  <= '0;
        end else begin
            state_q       <= state_d;
            ic_resp_valid <= resp_take && !owner_q;
            dc_resp_valid <= (resp_take && owner_q) || write_done;

            if (accept) begin
                last_grant_q <= grant_dc;
                owner_q      <= grant_dc;
                rw_q         <= grant_dc && dc_req_rw;
                mem_req_addr <= grant_dc ? dc_req_addr : ic_req_addr;
                mem_wdata    <= (grant_dc && dc_req_rw) ? dc_req_wdata : '0;
                mem_wmask    <= (grant_dc && dc_req_rw) ? dc_req_wmask : '0;
                req_done_q   <= 1'b0;
                wdata_done_q <= 1'b0;
            end else begin
                if (req_fire) begin
                    req_done_q <= 1'b1;
                end
                if (wdata_fire) begin
                    wdata_done_q <= 1'b1;
                end
            end

            if (resp_take) begin
                if (owner_q) begin
                    dc_resp_data <= mem_resp_data;
                end else begin
                    ic_resp_data <= mem_resp_data;
                end
            end
        end
    end

endmodule

// File: tb/tb_mem_req_arbiter.sv
// Directed bench for mem_req_arbiter: table of back-to-back reads plus
// hand-written reset, write, stall and spurious-response sequences.
module tb_mem_req_arbiter;

    localparam int unsigned AW = 32;
    localparam int unsigned DW = 128;
    localparam int unsigned MW = 16;

    logic          clk;
    logic          reset;
    logic          ic_req_valid, ic_req_ready;
    logic [AW-1:0] ic_req_addr;
    logic          ic_resp_valid;
    logic [DW-1:0] ic_resp_data;
    logic          dc_req_valid, dc_req_ready, dc_req_rw;
    logic [AW-1:0] dc_req_addr;
    logic [DW-1:0] dc_req_wdata;
    logic [MW-1:0] dc_req_wmask;
    logic          dc_resp_valid;
    logic [DW-1:0] dc_resp_data;
    logic          mem_req_valid, mem_req_ready, mem_req_rw;
    logic [AW-1:0] mem_req_addr;
    logic          mem_wdata_valid, mem_wdata_ready;
    logic [DW-1:0] mem_wdata;
    logic [MW-1:0] mem_wmask;
    logic          mem_resp_valid;
    logic [DW-1:0] mem_resp_data;
    logic          busy, owner;

    int passed = 0;
    int total  = 0;

    mem_req_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MASK_WIDTH(MW)) dut (
        .clk(clk), .reset(reset),
        .ic_req_valid(ic_req_valid), .ic_req_ready(ic_req_ready), .ic_req_addr(ic_req_addr),
        .ic_resp_valid(ic_resp_valid), .ic_resp_data(ic_resp_data),
        .dc_req_valid(dc_req_valid), .dc_req_ready(dc_req_ready), .dc_req_rw(dc_req_rw),
        .dc_req_addr(dc_req_addr), .dc_req_wdata(dc_req_wdata), .dc_req_wmask(dc_req_wmask),
        .dc_resp_valid(dc_resp_valid), .dc_resp_data(dc_resp_data),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_rw(mem_req_rw),
        .mem_req_addr(mem_req_addr), .mem_wdata_valid(mem_wdata_valid),
        .mem_wdata_ready(mem_wdata_ready), .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
        .mem_resp_valid(mem_resp_valid), .mem_resp_data(mem_resp_data),
        .busy(busy), .owner(owner)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic          ic_v;
        logic          dc_v;
        logic          exp_dc;
        logic [AW-1:0] ic_addr;
        logic [AW-1:0] dc_addr;
        logic [DW-1:0] rdata;
    } vec_t;

    vec_t tbl[9];

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        total++;
        if (act !== exp)
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        else
            passed++;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_owner"}, owner, 0);
        chk({tag, "_readys"}, {ic_req_ready, dc_req_ready}, 0);
        chk({tag, "_memvalids"}, {mem_req_valid, mem_wdata_valid, mem_req_rw}, 0);
        chk({tag, "_respvalids"}, {ic_resp_valid, dc_resp_valid}, 0);
        chk({tag, "_addr"}, mem_req_addr, 0);
        chk({tag, "_wdata"}, mem_wdata, 0);
        chk({tag, "_wmask"}, mem_wmask, 0);
        chk({tag, "_icdata"}, ic_resp_data, 0);
        chk({tag, "_dcdata"}, dc_resp_data, 0);
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        vec_t          r;
        logic          prev_dc;
        logic [DW-1:0] prev_data;
        logic [DW-1:0] last_dc_data;
        logic [DW-1:0] wd;
        logic [DW-1:0] rd;

        reset = 1'b0;
        ic_req_valid = 0; ic_req_addr = '0;
        dc_req_valid = 0; dc_req_rw = 0; dc_req_addr = '0; dc_req_wdata = '0; dc_req_wmask = '0;
        mem_req_ready = 0; mem_wdata_ready = 0; mem_resp_valid = 0; mem_resp_data = '0;

        tbl[0] = '{1'b1, 1'b1, 1'b1, 32'h1000, 32'h8000, {4{32'hD000_0000}}};
        tbl[1] = '{1'b1, 1'b0, 1'b0, 32'h1000, 32'h8040, {4{32'hD000_0001}}};
        tbl[2] = '{1'b1, 1'b1, 1'b1, 32'h1080, 32'h8080, {4{32'hD000_0002}}};
        tbl[3] = '{1'b1, 1'b1, 1'b0, 32'h1080, 32'h80C0, {4{32'hD000_0003}}};
        tbl[4] = '{1'b1, 1'b1, 1'b1, 32'h1100, 32'h8100, {4{32'hD000_0004}}};
        tbl[5] = '{1'b0, 1'b1, 1'b1, 32'h1140, 32'h8140, {4{32'hD000_0005}}};
        tbl[6] = '{1'b1, 1'b1, 1'b0, 32'h1180, 32'h8180, {4{32'hD000_0006}}};
        tbl[7] = '{1'b1, 1'b0, 1'b0, 32'h11C0, 32'h81C0, {4{32'hD000_0007}}};
        tbl[8] = '{1'b1, 1'b1, 1'b1, 32'h1200, 32'h8200, {4{32'hD000_0008}}};

        @(negedge clk);
        check_all_zero("rst");
        tick();
        reset = 1'b1;

        // Reset during RESP abandons the transaction
        dc_req_valid = 1; dc_req_rw = 0; dc_req_addr = 32'h3000; mem_req_ready = 1;
        @(negedge clk);
        chk("t1_dc_ready", dc_req_ready, 1);
        tick();
        dc_req_valid = 0;
        @(negedge clk);
        chk("t1_memreq_valid", mem_req_valid, 1);
        chk("t1_memreq_addr", mem_req_addr, 32'h3000);
        tick();
        reset = 0; mem_resp_valid = 1; mem_resp_data = {8{16'h5555}};
        @(negedge clk);
        check_all_zero("t1_inrst");
        tick();
        reset = 1;
        @(negedge clk);
        chk("t1_no_dc_resp", dc_resp_valid, 0);
        chk("t1_busy", busy, 0);
        tick();
        mem_resp_valid = 0;
        @(negedge clk);
        check_all_zero("t1_after");
        tick();

        // Single icache read at minimum latency
        ic_req_valid = 1; ic_req_addr = 32'h100; mem_req_ready = 1;
        @(negedge clk);
        chk("t2_c0_readys", {ic_req_ready, dc_req_ready}, 2'b10);
        tick();
        ic_req_valid = 0;
        @(negedge clk);
        chk("t2_c1_memreq", {mem_req_valid, mem_req_rw, busy, owner}, 4'b1010);
        chk("t2_c1_addr", mem_req_addr, 32'h100);
        chk("t2_c1_wmask", mem_wmask, 0);
        tick();
        mem_resp_valid = 1; mem_resp_data = {8{16'hAAAA}};
        @(negedge clk);
        chk("t2_c2_noresp", {ic_resp_valid, mem_req_valid}, 0);
        tick();
        mem_resp_valid = 0;
        @(negedge clk);
        chk("t2_c3_resp", {ic_resp_valid, dc_resp_valid, busy}, 3'b100);
        chk("t2_c3_data", ic_resp_data, {8{16'hAAAA}});
        tick();
        @(negedge clk);
        chk("t2_c4_pulse_end", ic_resp_valid, 0);
        tick();

        // Back-to-back reads with held losers: round-robin sequence from the table
        prev_dc = 0; prev_data = '0; last_dc_data = '0;
        mem_req_ready = 1; dc_req_rw = 0;
        for (int i = 0; i < 9; i++) begin
            r = tbl[i];
            ic_req_valid = r.ic_v; dc_req_valid = r.dc_v;
            ic_req_addr = r.ic_addr; dc_req_addr = r.dc_addr;
            mem_resp_valid = 0;
            @(negedge clk);
            chk($sformatf("v%0d_readys", i), {ic_req_ready, dc_req_ready}, {!r.exp_dc, r.exp_dc});
            if (i > 0) begin
                chk($sformatf("v%0d_prev_pulse", i), {ic_resp_valid, dc_resp_valid}, {!prev_dc, prev_dc});
                chk($sformatf("v%0d_prev_data", i), prev_dc ? dc_resp_data : ic_resp_data, prev_data);
            end
            tick();
            if (r.exp_dc) dc_req_valid = 0; else ic_req_valid = 0;
            @(negedge clk);
            chk($sformatf("v%0d_memreq", i), {mem_req_valid, mem_req_rw, owner}, {1'b1, 1'b0, r.exp_dc});
            chk($sformatf("v%0d_addr", i), mem_req_addr, r.exp_dc ? r.dc_addr : r.ic_addr);
            chk($sformatf("v%0d_c1_readys", i), {ic_req_ready, dc_req_ready}, 0);
            tick();
            mem_resp_valid = 1; mem_resp_data = r.rdata;
            @(negedge clk);
            chk($sformatf("v%0d_c2", i), {ic_req_ready, dc_req_ready, ic_resp_valid, dc_resp_valid, busy}, 5'b00001);
            tick();
            prev_dc = r.exp_dc; prev_data = r.rdata;
            if (r.exp_dc) last_dc_data = r.rdata;
        end
        ic_req_valid = 0; dc_req_valid = 0; mem_resp_valid = 0;
        @(negedge clk);
        chk("v_last_pulse", {ic_resp_valid, dc_resp_valid}, {!prev_dc, prev_dc});
        chk("v_last_data", prev_dc ? dc_resp_data : ic_resp_data, prev_data);
        tick();

        // dcache write, channels firing in different cycles
        wd = {4{32'hC0FF_EE00}};
        dc_req_valid = 1; dc_req_rw = 1; dc_req_addr = 32'h2000;
        dc_req_wdata = wd; dc_req_wmask = 16'hFFFF;
        mem_req_ready = 0; mem_wdata_ready = 0;
        @(negedge clk);
        chk("t4_c0_readys", {ic_req_ready, dc_req_ready}, 2'b01);
        tick();
        dc_req_valid = 0; ic_req_valid = 1; ic_req_addr = 32'h4000;
        @(negedge clk);
        chk("t4_c1_valids", {mem_req_valid, mem_wdata_valid, mem_req_rw, ic_req_ready}, 4'b1110);
        chk("t4_c1_addr", mem_req_addr, 32'h2000);
        chk("t4_c1_wdata", mem_wdata, wd);
        chk("t4_c1_wmask", mem_wmask, 16'hFFFF);
        tick();
        mem_req_ready = 1;
        @(negedge clk);
        chk("t4_c2_valids", {mem_req_valid, mem_wdata_valid, ic_req_ready}, 3'b110);
        tick();
        mem_req_ready = 0;
        @(negedge clk);
        chk("t4_c3_valids", {mem_req_valid, mem_wdata_valid, busy, ic_req_ready, dc_resp_valid}, 5'b01100);
        tick();
        mem_wdata_ready = 1;
        @(negedge clk);
        chk("t4_c4_valids", {mem_req_valid, mem_wdata_valid, ic_req_ready, dc_resp_valid}, 4'b0100);
        tick();
        mem_wdata_ready = 0;
        @(negedge clk);
        chk("t4_c5_resp", {dc_resp_valid, ic_resp_valid, busy, ic_req_ready}, 4'b1001);
        chk("t4_c5_dcdata", dc_resp_data, last_dc_data);
        tick();

        // icache read stalled by memory for 10 cycles, with a spurious response in REQ
        ic_req_valid = 0;
        dc_req_valid = 1; dc_req_rw = 0; dc_req_addr = 32'h5000;
        for (int k = 0; k < 10; k++) begin
            mem_resp_valid = (k == 3);
            mem_resp_data = {4{32'hBAD0_0000}};
            @(negedge clk);
            chk($sformatf("t5_k%0d_state", k),
                {mem_req_valid, busy, mem_req_rw, owner, ic_req_ready, dc_req_ready, ic_resp_valid, dc_resp_valid},
                8'b11000000);
            chk($sformatf("t5_k%0d_addr", k), mem_req_addr, 32'h4000);
            tick();
        end
        mem_resp_valid = 0; mem_req_ready = 1; dc_req_valid = 0;
        @(negedge clk);
        chk("t6_fire", mem_req_valid, 1);
        tick();
        rd = {4{32'h600D_DA7A}};
        mem_resp_valid = 1; mem_resp_data = rd;
        @(negedge clk);
        chk("t6_resp_cycle", {ic_resp_valid, busy}, 2'b01);
        tick();
        mem_resp_data = {4{32'hBAD1_1111}};
        @(negedge clk);
        chk("t6_pulse", {ic_resp_valid, dc_resp_valid, busy}, 3'b100);
        chk("t6_data", ic_resp_data, rd);
        tick();
        mem_resp_valid = 0;
        @(negedge clk);
        chk("t6_once", {ic_resp_valid, dc_resp_valid, busy}, 3'b000);
        chk("t6_data_kept", ic_resp_data, rd);
        tick();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
